// File: rtl/lote_pkg.sv
// ============================================================================
// Module  : lote_pkg
// Brief   : Shared FSM state encoding and verdict one-hot codes for the
//           lot supervisor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lote_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ALARM = 1'b1
    } lote_state_e;

    // Verdict bus is ordered {aceito, comprometido, recusado}
    localparam logic [2:0] VERDICT_ACEITO       = 3'b100;
    localparam logic [2:0] VERDICT_COMPROMETIDO = 3'b010;
    localparam logic [2:0] VERDICT_RECUSADO     = 3'b001;

endpackage : lote_pkg

`default_nettype wire

// File: rtl/lote_beeper.sv
// ============================================================================
// Module  : lote_beeper
// Brief   : Pulsed buzzer drive: down-counter plus toggle flop, high for
//           BEEP_HALF cycles then low for BEEP_HALF cycles while en=1.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lote_beeper #(
    parameter int BEEP_HALF = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic beep
);

    localparam int c_cnt_w = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(BEEP_HALF - 1);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               beep_q, beep_d;

    // Cleared state (cnt=0, beep=0) makes the first enabled edge toggle high.
    always_comb begin
        cnt_d  = cnt_q;
        beep_d = beep_q;
        if (!en) begin
            cnt_d  = '0;
            beep_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d  = c_reload;
            beep_d = ~beep_q;
        end else begin
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            beep_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beep_q <= beep_d;
        end
    end

    assign beep = beep_q;

endmodule : lote_beeper

`default_nettype wire

// File: rtl/lote_supervisor.sv
// ============================================================================
// Module  : lote_supervisor
// Brief   : Tallies lot verdicts, tracks consecutive rejects and halts the
//           line with a buzzer until acknowledged. Define LOTE_BUZZER_PULSE_EN
//           for a pulsed buzzer instead of a steady tone.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module lote_supervisor
    import lote_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int REJ_LIMIT = 3,
    parameter int BEEP_HALF = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lote_valido,
    input  logic             lote_aceito,
    input  logic             lote_comprometido,
    input  logic             lote_recusado,
    input  logic             alarm_ack,
    input  logic             clear_counts,
    output logic [CNT_W-1:0] cnt_aceito,
    output logic [CNT_W-1:0] cnt_comprometido,
    output logic [CNT_W-1:0] cnt_recusado,
    output logic [CNT_W-1:0] cnt_invalido,
    output logic             linha_parada,
    output logic             sound_buzzer
);

    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_rej_limit = CNT_W'(REJ_LIMIT);

    if (REJ_LIMIT < 1 || REJ_LIMIT > (2**CNT_W) - 1 || BEEP_HALF < 1) begin : g_param_check
        $error("lote_supervisor: parameter out of range");
    end

    lote_state_e      state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] comp_q, comp_d;
    logic [CNT_W-1:0] rec_q, rec_d;
    logic [CNT_W-1:0] inv_q, inv_d;
    logic [CNT_W-1:0] streak_q, streak_d;

    logic [2:0] verdict;
    logic       strobe, is_acc, is_comp, is_rec, is_inv, is_reject;

    // A clear in the same cycle discards the strobe entirely.
    assign verdict   = {lote_aceito, lote_comprometido, lote_recusado};
    assign strobe    = lote_valido & ~clear_counts;
    assign is_acc    = strobe && (verdict == VERDICT_ACEITO);
    assign is_comp   = strobe && (verdict == VERDICT_COMPROMETIDO);
    assign is_rec    = strobe && (verdict == VERDICT_RECUSADO);
    assign is_inv    = strobe && !(is_acc || is_comp || is_rec);
    assign is_reject = is_rec | is_inv;

    always_comb begin
        acc_d    = acc_q;
        comp_d   = comp_q;
        rec_d    = rec_q;
        inv_d    = inv_q;
        streak_d = streak_q;
        state_d  = state_q;

        if (clear_counts) begin
            acc_d    = '0;
            comp_d   = '0;
            rec_d    = '0;
            inv_d    = '0;
            streak_d = '0;
        end else begin
            if (is_acc  && acc_q  != c_cnt_max) acc_d  = acc_q  + 1'b1;
            if (is_comp && comp_q != c_cnt_max) comp_d = comp_q + 1'b1;
            if (is_rec  && rec_q  != c_cnt_max) rec_d  = rec_q  + 1'b1;
            if (is_inv  && inv_q  != c_cnt_max) inv_d  = inv_q  + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (is_acc) begin
                    streak_d = '0;
                end else if (is_reject && streak_q != c_rej_limit) begin
                    streak_d = streak_q + 1'b1;
                end
                if (streak_d == c_rej_limit) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                // Streak stays frozen here; only ack returns to RUN.
                if (alarm_ack) begin
                    state_d  = ST_RUN;
                    streak_d = '0;
                end
            end
            default: begin
                state_d  = ST_RUN;
                streak_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            acc_q    <= '0;
            comp_q   <= '0;
            rec_q    <= '0;
            inv_q    <= '0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            comp_q   <= comp_d;
            rec_q    <= rec_d;
            inv_q    <= inv_d;
            streak_q <= streak_d;
        end
    end

    assign cnt_aceito       = acc_q;
    assign cnt_comprometido = comp_q;
    assign cnt_recusado     = rec_q;
    assign cnt_invalido     = inv_q;
    assign linha_parada     = (state_q == ST_ALARM);

`ifdef LOTE_BUZZER_PULSE_EN
    logic alarm_en;
    logic beep;

    // Enable from next state so the first high phase coincides with the halt.
    assign alarm_en = (state_d == ST_ALARM);

    lote_beeper #(
        .BEEP_HALF (BEEP_HALF)
    ) u_beeper (
        .clk  (clk),
        .rst  (rst),
        .en   (alarm_en),
        .beep (beep)
    );

    assign sound_buzzer = beep;
`else
    assign sound_buzzer = (state_q == ST_ALARM);
`endif

endmodule : lote_supervisor

`default_nettype wire

// File: tb/tb_lote_supervisor.sv
// ============================================================================
// Module  : tb_lote_supervisor
// Brief   : Scoreboard bench for lote_supervisor (CNT_W=4, REJ_LIMIT=3):
//           directed scenarios followed by randomized traffic.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lote_supervisor;

    localparam int TB_CNT_W = 4;
    localparam int TB_LIM   = 3;
    localparam int TB_BEEP  = 4;
    localparam int TB_MAX   = (1 << TB_CNT_W) - 1;

    typedef struct packed {
        logic [TB_CNT_W-1:0] acc;
        logic [TB_CNT_W-1:0] comp;
        logic [TB_CNT_W-1:0] rec;
        logic [TB_CNT_W-1:0] inv;
        logic                halt;
        logic                buzz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valido = 1'b0, aceito = 1'b0, comprometido = 1'b0, recusado = 1'b0;
    logic ack = 1'b0, clr = 1'b0;
    logic [TB_CNT_W-1:0] o_acc, o_comp, o_rec, o_inv;
    logic o_halt, o_buzz;

    always #5 clk = ~clk;

    lote_supervisor #(
        .CNT_W     (TB_CNT_W),
        .REJ_LIMIT (TB_LIM),
        .BEEP_HALF (TB_BEEP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .lote_valido       (valido),
        .lote_aceito       (aceito),
        .lote_comprometido (comprometido),
        .lote_recusado     (recusado),
        .alarm_ack         (ack),
        .clear_counts      (clr),
        .cnt_aceito        (o_acc),
        .cnt_comprometido  (o_comp),
        .cnt_recusado      (o_rec),
        .cnt_invalido      (o_inv),
        .linha_parada      (o_halt),
        .sound_buzzer      (o_buzz)
    );

    // Reference model: plain integers following the verdict rules.
    int m_acc, m_comp, m_rec, m_inv, m_streak, m_age;
    bit m_alarm;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic int sat(input int v);
        return (v >= TB_MAX) ? TB_MAX : v + 1;
    endfunction

    task automatic model_step(input bit r, input bit v, input bit a, input bit c,
                              input bit j, input bit k, input bit cl);
        int  ones;
        bit  strobe, reject, was_alarm;
        exp_t e;
        if (r) begin
            m_acc = 0; m_comp = 0; m_rec = 0; m_inv = 0;
            m_streak = 0; m_alarm = 0; m_age = 0;
        end else begin
            ones      = int'(a) + int'(c) + int'(j);
            strobe    = v && !cl;
            reject    = strobe && (ones != 1 || j);
            was_alarm = m_alarm;
            if (cl) begin
                m_acc = 0; m_comp = 0; m_rec = 0; m_inv = 0; m_streak = 0;
            end else if (strobe) begin
                if (ones != 1) m_inv = sat(m_inv);
                else if (a)    m_acc = sat(m_acc);
                else if (c)    m_comp = sat(m_comp);
                else           m_rec = sat(m_rec);
            end
            if (!was_alarm) begin
                if (strobe && ones == 1 && a) m_streak = 0;
                else if (reject && m_streak < TB_LIM) m_streak = m_streak + 1;
                if (m_streak == TB_LIM) begin
                    m_alarm = 1;
                    m_age   = 0;
                end
            end else if (k) begin
                m_alarm  = 0;
                m_streak = 0;
            end else begin
                m_age = m_age + 1;
            end
        end
        e.acc  = TB_CNT_W'(m_acc);
        e.comp = TB_CNT_W'(m_comp);
        e.rec  = TB_CNT_W'(m_rec);
        e.inv  = TB_CNT_W'(m_inv);
        e.halt = m_alarm;
`ifdef LOTE_BUZZER_PULSE_EN
        e.buzz = m_alarm && (((m_age / TB_BEEP) % 2) == 0);
`else
        e.buzz = m_alarm;
`endif
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: apply inputs, advance the model, queue expectation.
    task automatic drive(input bit r, input bit v, input logic [2:0] vd,
                         input bit k, input bit cl);
        @(negedge clk);
        rst = r; valido = v;
        aceito = vd[2]; comprometido = vd[1]; recusado = vd[0];
        ack = k; clr = cl;
        model_step(r, v, vd[2], vd[1], vd[0], k, cl);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic strobe(input logic [2:0] vd);
        drive(1'b0, 1'b1, vd, 1'b0, 1'b0);
        idle();
    endtask

    task automatic do_ack();
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents a full output word.
    always @(posedge clk) begin
        exp_t e;
        exp_t got;
        #1;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{o_acc, o_comp, o_rec, o_inv, o_halt, o_buzz};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got acc=%0d comp=%0d rec=%0d inv=%0d halt=%b buzz=%b exp acc=%0d comp=%0d rec=%0d inv=%0d halt=%b buzz=%b",
                         $time, got.acc, got.comp, got.rec, got.inv, got.halt, got.buzz,
                         e.acc, e.comp, e.rec, e.inv, e.halt, e.buzz);
            end
        end
    end

    initial begin
        logic [2:0] vd;
        // 1. reset with random inputs, then five accepts
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) strobe(3'b100);
        // 2. three rejects -> alarm; ack; then R R A R -> no alarm
        for (int i = 0; i < 3; i++) strobe(3'b001);
        idle();
        do_ack();
        idle();
        strobe(3'b001); strobe(3'b001); strobe(3'b100); strobe(3'b001);
        // 3. reach alarm, compromised strobe while halted, ack, two rejects no alarm
        strobe(3'b001); strobe(3'b001);
        strobe(3'b010);
        do_ack();
        strobe(3'b001); strobe(3'b001);
        strobe(3'b100);
        // 4. invalid patterns count as rejects
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        strobe(3'b000); strobe(3'b101); strobe(3'b001);
        // ack together with a strobe: tally counted, streak still zero
        drive(1'b0, 1'b1, 3'b001, 1'b1, 1'b0);
        strobe(3'b001);
        strobe(3'b100);
        // 5. saturation, then clear together with a strobe
        for (int i = 0; i < 20; i++) strobe(3'b100);
        drive(1'b0, 1'b1, 3'b100, 1'b0, 1'b1);
        idle();
        // 6. long alarm to observe buzzer, clear while halted, clear+ack together
        for (int i = 0; i < 3; i++) strobe(3'b001);
        for (int i = 0; i < 12; i++) idle();
        drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        drive(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
        idle();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       vd = 3'b100;
                1:       vd = 3'b010;
                2:       vd = 3'b001;
                default: vd = 3'($urandom);
            endcase
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 1) == 1),
                  vd,
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 39) == 0));
        end
        idle();
        idle();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_lote_supervisor

`default_nettype wire
